// File: rtl/fall_feat_pkg.sv
// Shared types and constants for the fall-detection feature extractor.
package fall_feat_pkg;

    typedef enum logic [1:0] {
        ACCUM = 2'd0,
        MEAN  = 2'd1,
        VAR   = 2'd2,
        SQRT  = 2'd3
    } feat_state_t;

    localparam int FEAT_W    = 32;
    localparam int SQRT_ITER = 16;

endpackage

// File: rtl/fall_feature_extractor_isqrt32.sv
// Sequential restoring integer square root: 16 iterations, one root bit per clock.
// The first iteration runs on the go edge itself; done flags the cycle before the final edge.
module isqrt32
    import fall_feat_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        go,
    input  logic [31:0] radicand,
    output logic [15:0] root,
    output logic        done
);

    logic [31:0] rad_q;
    logic [17:0] rem_q;
    logic [15:0] root_q;
    logic [3:0]  iter;
    logic        busy;

    logic [17:0] cur_rem;
    logic [15:0] cur_root;
    logic [1:0]  cur_bits;
    logic [19:0] shifted;
    logic [19:0] trial;
    logic [19:0] next_rem;
    logic        take;
    logic [15:0] next_root;

    // One restoring step; on go it starts from a fresh remainder and the radicand's top bits.
    always_comb begin
        cur_rem  = rem_q;
        cur_root = root_q;
        cur_bits = rad_q[31:30];
        if (go) begin
            cur_rem  = '0;
            cur_root = '0;
            cur_bits = radicand[31:30];
        end
        shifted   = {cur_rem, cur_bits};
        trial     = {2'b00, cur_root, 2'b01};
        take      = (shifted >= trial);
        next_rem  = take ? (shifted - trial) : shifted;
        next_root = {cur_root[14:0], take};
    end

    assign root = next_root;
    assign done = busy && (iter == 4'(SQRT_ITER - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            busy   <= 1'b0;
            iter   <= '0;
            rad_q  <= '0;
            rem_q  <= '0;
            root_q <= '0;
        end else if (go) begin
            busy   <= 1'b1;
            iter   <= 4'd1;
            rad_q  <= {radicand[29:0], 2'b00};
            rem_q  <= 18'(next_rem);
            root_q <= next_root;
        end else if (busy) begin
            iter   <= iter + 4'd1;
            rad_q  <= {rad_q[29:0], 2'b00};
            rem_q  <= 18'(next_rem);
            root_q <= next_root;
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/fall_feature_extractor.sv
// Windowed mean / standard-deviation front end feeding svm_inference.
// Build option: define FALL_FEAT_MEAN_ROUND_EN for a round-half-up mean instead of floor.
module fall_feature_extractor
    import fall_feat_pkg::*;
#(
    parameter int WINDOW_LOG2 = 5,
    parameter int SAMPLE_W    = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                sample_valid,
    input  logic [SAMPLE_W-1:0] sample_data,
    output logic                sample_ready,
    output logic [FEAT_W-1:0]   feature_mean,
    output logic [FEAT_W-1:0]   feature_std,
    output logic                start
);

    localparam int SUM_W  = SAMPLE_W + WINDOW_LOG2;
    localparam int SQ_W   = 2 * SAMPLE_W + WINDOW_LOG2;
    localparam int PROD_W = 2 * SAMPLE_W;

    feat_state_t                state;
    logic signed [SUM_W-1:0]    sum;
    logic [SQ_W-1:0]            sumsq;
    logic [WINDOW_LOG2-1:0]     cnt;
    logic signed [FEAT_W-1:0]   mean_q;
    logic [FEAT_W-1:0]          var_q;
    logic                       sqrt_go;
    logic [15:0]                root;
    logic                       sqrt_done;

    logic signed [PROD_W-1:0]   sample_ext;
    logic signed [PROD_W-1:0]   sample_sq;
    logic signed [FEAT_W-1:0]   sum_ext;
    logic signed [FEAT_W-1:0]   mean_calc;
    logic [FEAT_W-1:0]          msq;
    logic signed [FEAT_W:0]     mean33;
    logic signed [FEAT_W:0]     var_diff;
    logic                       transfer;

    assign sample_ready = (state == ACCUM);
    assign transfer     = sample_valid && sample_ready;

    // Square, mean and variance datapath; a square is never negative so it zero-extends into sumsq.
    always_comb begin
        sample_ext = PROD_W'($signed(sample_data));
        sample_sq  = sample_ext * sample_ext;
        sum_ext    = FEAT_W'(sum);
`ifdef FALL_FEAT_MEAN_ROUND_EN
        mean_calc  = $signed(sum_ext + $signed(FEAT_W'(1 << (WINDOW_LOG2 - 1)))) >>> WINDOW_LOG2;
`else
        mean_calc  = sum_ext >>> WINDOW_LOG2;
`endif
        msq        = FEAT_W'(sumsq >> WINDOW_LOG2);
        mean33     = (FEAT_W + 1)'(mean_q);
        var_diff   = $signed({1'b0, msq}) - (mean33 * mean33);
    end

    isqrt32 u_isqrt (
        .clk      (clk),
        .reset_n  (reset_n),
        .go       (sqrt_go),
        .radicand (var_q),
        .root     (root),
        .done     (sqrt_done)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= ACCUM;
            sum          <= '0;
            sumsq        <= '0;
            cnt          <= '0;
            mean_q       <= '0;
            var_q        <= '0;
            sqrt_go      <= 1'b0;
            feature_mean <= '0;
            feature_std  <= '0;
            start        <= 1'b0;
        end else begin
            start   <= 1'b0;
            sqrt_go <= 1'b0;
            unique case (state)
                ACCUM: begin
                    if (transfer) begin
                        sum   <= sum + SUM_W'($signed(sample_data));
                        sumsq <= sumsq + SQ_W'($unsigned(sample_sq));
                        if (cnt == {WINDOW_LOG2{1'b1}}) begin
                            cnt   <= '0;
                            state <= MEAN;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                MEAN: begin
                    mean_q <= mean_calc;
                    state  <= VAR;
                end
                VAR: begin
                    // Rounding in the mean can push mean^2 above the mean square, hence the clamp.
                    var_q   <= var_diff[FEAT_W] ? '0 : var_diff[FEAT_W-1:0];
                    sqrt_go <= 1'b1;
                    state   <= SQRT;
                end
                SQRT: begin
                    if (sqrt_done) begin
                        feature_mean <= mean_q;
                        feature_std  <= {16'b0, root};
                        start        <= 1'b1;
                        sum          <= '0;
                        sumsq        <= '0;
                        state        <= ACCUM;
                    end
                end
                default: state <= ACCUM;
            endcase
        end
    end

endmodule

// File: tb/tb_fall_feature_extractor.sv
// Directed self-checking bench for fall_feature_extractor (default parameters).
module tb_fall_feature_extractor;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        sample_valid = 1'b0;
    logic [15:0] sample_data = '0;
    logic        sample_ready;
    logic [31:0] feature_mean;
    logic [31:0] feature_std;
    logic        start;

    int errors = 0;
    int checks = 0;
    int cycle = 0;
    int start_count = 0;
    int xfer_cycle = 0;
    int saved_starts;

    fall_feature_extractor dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_ready (sample_ready),
        .feature_mean (feature_mean),
        .feature_std  (feature_std),
        .start        (start)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cycle <= cycle + 1;
        if (start === 1'b1) start_count <= start_count + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Offer one sample (called at a negedge) and return at the negedge after it is accepted.
    task automatic applyStimulus(input logic [15:0] d);
        int guard = 0;
        sample_valid = 1'b1;
        sample_data  = d;
        while (sample_ready !== 1'b1 && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 64) checkOutput("ready_timeout", 32'(sample_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        xfer_cycle = cycle;
    endtask

    task automatic waitForStart(input string tag, input logic [31:0] exp_mean, input logic [31:0] exp_std);
        int guard = 0;
        while (start !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        if (start !== 1'b1) begin
            checkOutput({tag, "_start_timeout"}, 32'd0, 32'd1);
        end else begin
            sample_valid = 1'b0;
            checkOutput({tag, "_latency"}, 32'(cycle - xfer_cycle), 32'd18);
            checkOutput({tag, "_mean"}, feature_mean, exp_mean);
            checkOutput({tag, "_std"}, feature_std, exp_std);
            checkOutput({tag, "_ready_back"}, 32'(sample_ready), 32'd1);
            @(negedge clk);
            checkOutput({tag, "_start_single"}, 32'(start), 32'd0);
            checkOutput({tag, "_mean_held"}, feature_mean, exp_mean);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready", 32'(sample_ready), 32'd1);
        checkOutput("rst_start", 32'(start), 32'd0);
        checkOutput("rst_mean", feature_mean, 32'd0);
        checkOutput("rst_std", feature_std, 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // Constant +100
        for (int i = 0; i < 32; i++) applyStimulus(16'd100);
        sample_valid = 1'b0;
        checkOutput("t1_ready_low", 32'(sample_ready), 32'd0);
        waitForStart("t1", 32'd100, 32'd0);

        // Alternating +10 / -10
        for (int i = 0; i < 32; i++) applyStimulus((i % 2 == 0) ? 16'sd10 : -16'sd10);
        sample_valid = 1'b0;
        waitForStart("t2", 32'd0, 32'd10);

        // Ramp 0..31
        for (int i = 0; i < 32; i++) applyStimulus(16'(i));
        sample_valid = 1'b0;
`ifdef FALL_FEAT_MEAN_ROUND_EN
        waitForStart("t3", 32'd16, 32'd8);
`else
        waitForStart("t3", 32'd15, 32'd10);
`endif

        // Constant -3
        for (int i = 0; i < 32; i++) applyStimulus(-16'sd3);
        sample_valid = 1'b0;
        waitForStart("t4", 32'hFFFF_FFFD, 32'd0);

        // Partial window discarded by reset
        for (int i = 0; i < 10; i++) applyStimulus(16'd7);
        sample_valid = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        checkOutput("t5_rst_mean", feature_mean, 32'd0);
        checkOutput("t5_rst_ready", 32'(sample_ready), 32'd1);
        reset_n = 1'b1;
        saved_starts = start_count;
        for (int i = 0; i < 32; i++) applyStimulus(16'd50);
        sample_valid = 1'b0;
        checkOutput("t5_no_early_start", 32'(start_count), 32'(saved_starts));
        waitForStart("t5", 32'd50, 32'd0);

        // 999 offered throughout compute must be ignored
        for (int i = 0; i < 32; i++) applyStimulus(16'd40);
        sample_data = 16'd999;
        checkOutput("t6_ready_low_n", 32'(sample_ready), 32'd0);
        repeat (10) @(negedge clk);
        checkOutput("t6_ready_low_sqrt", 32'(sample_ready), 32'd0);
        waitForStart("t6a", 32'd40, 32'd0);
        for (int i = 0; i < 32; i++) applyStimulus(16'd20);
        sample_valid = 1'b0;
        waitForStart("t6b", 32'd20, 32'd0);

        // Negative mean with spread: -5/-15 gives mean -10, std 5
        for (int i = 0; i < 32; i++) applyStimulus((i % 2 == 0) ? -16'sd5 : -16'sd15);
        sample_valid = 1'b0;
        waitForStart("t8", 32'hFFFF_FFF6, 32'd5);

        // Reset on the edge that would raise start
        for (int i = 0; i < 32; i++) applyStimulus(16'd8);
        sample_valid = 1'b0;
        saved_starts = start_count;
        repeat (17) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        checkOutput("t7_start_suppressed", 32'(start), 32'd0);
        checkOutput("t7_mean_cleared", feature_mean, 32'd0);
        checkOutput("t7_ready", 32'(sample_ready), 32'd1);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("t7_no_late_start", 32'(start_count), 32'(saved_starts));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fall_feature_extractor.md
# fall_feature_extractor

Windowed statistics front end for fall detection. Accepts a stream of signed acceleration-magnitude samples, accumulates a fixed window of 2^WINDOW_LOG2 samples, then computes the window mean and standard deviation. It presents both to `svm_inference` as `feature_mean` / `feature_std` with a one-cycle `start` pulse. It sits between the sensor sample pipeline and the SVM classifier and drives the classifier's entire input side.

## Interface
- `WINDOW_LOG2`, default 5: window length is 2^WINDOW_LOG2 samples; legal range 1..8.
- `SAMPLE_W`, default 16: signed sample width; legal range 8..16.
- `clk`  in  1  single clock; all logic on the rising edge.
- `reset_n`  in  1  reset, synchronous and active-low.
- `sample_valid`  in  1  `sample_data` is valid this cycle.
- `sample_data`  in  SAMPLE_W  signed sample.
- `sample_ready`  out  1  block accepts a sample this cycle. A transfer occurs when `sample_valid` and `sample_ready` are both high.
- `feature_mean`  out  32  signed window mean, sign-extended; held until the next `start`.
- `feature_std`  out  32  unsigned window standard deviation, zero-extended; held until the next `start`.
- `start`  out  1  one-cycle pulse: new features are valid; connects to `svm_inference.start`.

## Operation
- States: ACCUM, MEAN, VAR, SQRT.
- **ACCUM**
  - `sample_ready` = 1.
  - Each transfer adds the sample to `sum` (signed, SAMPLE_W+WINDOW_LOG2 bits), adds sample² to `sumsq` (unsigned, 2·SAMPLE_W+WINDOW_LOG2 bits), and increments `cnt`.
  - The transfer that makes `cnt` reach 2^WINDOW_LOG2 moves the block to MEAN and clears `cnt`.
- **MEAN** (1 cycle): `mean = sum >>> WINDOW_LOG2`, an arithmetic shift, so the result is floored toward −∞.
- **VAR** (1 cycle)
  - `var = (sumsq >> WINDOW_LOG2) − mean·mean`, computed in 33-bit signed arithmetic.
  - A negative result is clamped to 0. The remaining 32-bit unsigned value is the sqrt radicand.
- **SQRT** (16 cycles)
  - Restoring integer square root, one result bit per cycle, MSB first: `std = floor(sqrt(var))`, 16 bits.
  - On the 16th iteration edge: register `feature_mean` and `feature_std`, set `start` = 1, clear `sum`/`sumsq`, return to ACCUM.
- While not in ACCUM, `sample_ready` = 0 and `sample_valid` is ignored; no sample is lost or double-counted.
- Windows do not overlap; the next window starts with the first transfer after returning to ACCUM.
- Reset, at any time including mid-window or mid-SQRT:
  - state → ACCUM; `sum`, `sumsq`, `cnt` cleared.
  - `feature_mean` = 0, `feature_std` = 0, `start` = 0, `sample_ready` = 1 in the first cycle after the reset edge.
  - A partial window is discarded.

## Timing
- Let edge N be the edge that accepts the last sample of a window.
  - `sample_ready` is low after edge N.
  - MEAN is evaluated at edge N+1, VAR at edge N+2, and SQRT iterations at edges N+3..N+18.
  - `start` is high in the single cycle after edge N+18. The new `feature_*` values are visible in that same cycle.
  - `sample_ready` returns high in that same cycle.
- Fixed latency: 18 clocks from the last-sample edge to the `start` cycle.
- Throughput: one window per 2^WINDOW_LOG2 + 18 cycles with continuous valid input.
- `start` never stays high for 2 consecutive cycles.
- `reset_n` low on the same edge that would raise `start`: reset wins, and `start` stays 0.

## Configuration
- `FALL_FEAT_MEAN_ROUND_EN`
  - Defined: mean = `(sum + 2^(WINDOW_LOG2−1)) >>> WINDOW_LOG2`, i.e. round half up. VAR uses this rounded mean; the negative clamp still applies.
  - Undefined: floor as above.
- Latency is identical in both builds.

## Structure
- Package `fall_feat_pkg`:
  - state enum `feat_state_t` (ACCUM, MEAN, VAR, SQRT)
  - `FEAT_W = 32`
  - `SQRT_ITER = 16`
- Sub-module `isqrt32`:
  - Interface: `clk`, `reset_n`, `go`, 32-bit radicand, 16-bit root, `done`.
  - Sequential restoring algorithm, 16 cycles after `go`.
  - The parent sequences it through the SQRT state.

## Test plan
- 32 samples of +100 back to back → `start` 18 cycles after the last transfer; mean = 100, std = 0.
- Alternating +10/−10 (32 samples) → mean = 0, std = 10.
- Samples 0,1,…,31 → floor build: mean = 15, var = 325 − 225 = 100, std = 10. Macro build: mean = 16, var = 325 − 256 = 69, std = 8.
- 32 samples of −3 → mean = −3 (`0xFFFFFFFD`), std = 0.
- 10 samples of 7, reset_n low 1 cycle, then 32 samples of 50 → mean = 50, std = 0; no `start` before the second window completes.
- `sample_valid` held high through compute, with samples of 999 offered during SQRT → `sample_ready` = 0, those samples are not counted, and the next window's result excludes them.
